// File: rtl/mbu_ctrl_glue.sv
// Memory Bank Unit control/glue: MBR window and CU micro-address decode,
// the enable and auto-index flip-flops, and the AEXT drive onto IBUS/DB.
module mbu_ctrl_glue (
  input  logic        clk,
  input  logic        nreset,
  input  logic        t34,
  input  logic [4:0]  raddr,
  input  logic [4:0]  waddr,
  input  logic        nir_idx,
  input  logic [7:0]  ab,
  input  logic        nsysdev,
  input  logic        nr,
  input  logic        nw,
  input  logic        nfpram_rom,
  input  logic [7:0]  rd,
  output logic [7:0]  aext,
  inout  wire  [7:0]  ibus,
  inout  wire  [15:0] db,
  output logic        niombr,
  output logic        nrmbp,
  output logic        nwmbp,
  output logic        nwar,
  output logic        niowmbr,
  output logic        nen,
  output logic        ndis,
  output logic        nir_idxreg
);

  logic nen_q;
  logic nir_idxreg_q;

  // I/O window &008-&00F in system-device space; ab[2:0] select the MBR.
  always_comb begin
    niombr  = ~(~ab[7] & ab[3] & (ab[6:4] == 3'b000) & ~nsysdev);
    nrmbp   = ~((raddr == 5'b01101) & ~t34);
    nwmbp   = ~(~waddr[4] & (waddr[3:1] == 3'b110));
    nwar    = ~(waddr[4:2] == 3'b001);
    niowmbr = niombr | nw;
  end

  // Unclocked set/reset storage: any I/O write into the window enables the
  // MBU, only reset disables it again.
  always_latch begin
    if (!nreset)
      nen_q <= 1'b1;
    else if (!niowmbr)
      nen_q <= 1'b0;
  end

  // Auto-index: set low asynchronously by the CU, released on the next clk rise.
  always_ff @(posedge clk or negedge nreset or negedge nir_idx) begin
    if (!nreset)
      nir_idxreg_q <= 1'b1;
    else if (!nir_idx)
      nir_idxreg_q <= 1'b0;
    else
      nir_idxreg_q <= 1'b1;
  end

  assign nen        = nen_q;
  assign ndis       = ~nen_q;
  assign nir_idxreg = nir_idxreg_q;

  assign aext = nen_q ? {nfpram_rom, 7'b0} : rd;

  assign ibus      = !nrmbp ? aext : 8'hzz;
  assign db[7:0]   = (!niombr && !nr) ? aext  : 8'hzz;
  assign db[15:8]  = (!niombr && !nr) ? 8'h54 : 8'hzz;

endmodule

// File: tb/tb_mbu_ctrl_glue.sv
// Self-checking bench for mbu_ctrl_glue: directed scenarios plus a randomized
// run against a behavioural model of the decode and the two state bits.
module tb_mbu_ctrl_glue;

  logic        clk = 1'b0;
  logic        nreset, t34, nir_idx, nsysdev, nr, nw, nfpram_rom;
  logic [4:0]  raddr, waddr;
  logic [7:0]  ab, rd;
  logic [7:0]  aext;
  wire  [7:0]  ibus;
  wire  [15:0] db;
  logic        niombr, nrmbp, nwmbp, nwar, niowmbr, nen, ndis, nir_idxreg;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: MBU enabled, auto-index latch set (active)
  bit en_m;
  bit idx_m;

  mbu_ctrl_glue dut (
    .clk(clk), .nreset(nreset), .t34(t34), .raddr(raddr), .waddr(waddr),
    .nir_idx(nir_idx), .ab(ab), .nsysdev(nsysdev), .nr(nr), .nw(nw),
    .nfpram_rom(nfpram_rom), .rd(rd), .aext(aext), .ibus(ibus), .db(db),
    .niombr(niombr), .nrmbp(nrmbp), .nwmbp(nwmbp), .nwar(nwar),
    .niowmbr(niowmbr), .nen(nen), .ndis(ndis), .nir_idxreg(nir_idxreg)
  );

  always #5 clk = ~clk;

  function automatic bit win_sel(input logic [7:0] a, input logic sd);
    return (sd == 1'b0) && (a >= 8'h08) && (a <= 8'h0F);
  endfunction

  function automatic bit rmbp_sel(input logic [4:0] r, input logic t);
    return (r == 5'd13) && (t == 1'b0);
  endfunction

  function automatic bit wmbp_sel(input logic [4:0] w);
    return (w == 5'd12) || (w == 5'd13);
  endfunction

  function automatic bit war_sel(input logic [4:0] w);
    return (w >= 5'd4) && (w <= 5'd7);
  endfunction

  function automatic logic [7:0] aext_m();
    return en_m ? rd : (nfpram_rom ? 8'h80 : 8'h00);
  endfunction

  task automatic idle_inputs();
    t34 = 1'b1; raddr = 5'd0; waddr = 5'd0; nir_idx = 1'b1; ab = 8'h00;
    nsysdev = 1'b1; nr = 1'b1; nw = 1'b1; nfpram_rom = 1'b1; rd = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    nreset = 1'b1;
    #3 nreset = 1'b0;
    #1;
    n_chk++; if (nen !== 1'b1) begin n_fail++; $display("FAIL reset_nen: got %b expected 1", nen); end
    n_chk++; if (ndis !== 1'b0) begin n_fail++; $display("FAIL reset_ndis: got %b expected 0", ndis); end
    n_chk++; if (nir_idxreg !== 1'b1) begin n_fail++; $display("FAIL reset_idx: got %b expected 1", nir_idxreg); end
    rd = 8'h5A; #1;
    n_chk++; if (aext !== 8'h80) begin n_fail++; $display("FAIL reset_aext_rom1: got %h expected 80", aext); end
    nfpram_rom = 1'b0; #1;
    n_chk++; if (aext !== 8'h00) begin n_fail++; $display("FAIL reset_aext_rom0: got %h expected 00", aext); end
    nfpram_rom = 1'b1;
    @(negedge clk) nreset = 1'b1;
    #1;
    n_chk++; if (nen !== 1'b1) begin n_fail++; $display("FAIL reset_release_nen: got %b expected 1", nen); end
  endtask

  task automatic test_outside_window();
    // write strobes outside the window must not enable the MBU
    ab = 8'h8B; nsysdev = 1'b0; nw = 1'b0; #1;
    n_chk++; if (niombr !== 1'b1) begin n_fail++; $display("FAIL outwin_ab7_niombr: got %b expected 1", niombr); end
    nw = 1'b1; #1;
    n_chk++; if (nen !== 1'b1) begin n_fail++; $display("FAIL outwin_ab7_nen: got %b expected 1", nen); end
    ab = 8'h0B; nsysdev = 1'b1; nw = 1'b0; #1;
    n_chk++; if (niombr !== 1'b1) begin n_fail++; $display("FAIL outwin_sysdev_niombr: got %b expected 1", niombr); end
    nw = 1'b1; #1;
    n_chk++; if (nen !== 1'b1) begin n_fail++; $display("FAIL outwin_sysdev_nen: got %b expected 1", nen); end
    ab = 8'h07; nsysdev = 1'b0; nw = 1'b0; #1; nw = 1'b1; #1;
    n_chk++; if (nen !== 1'b1) begin n_fail++; $display("FAIL outwin_07_nen: got %b expected 1", nen); end
  endtask

  task automatic test_enable();
    ab = 8'h0B; nsysdev = 1'b0; nw = 1'b0; #1;
    n_chk++; if (niombr !== 1'b0) begin n_fail++; $display("FAIL en_niombr: got %b expected 0", niombr); end
    n_chk++; if (niowmbr !== 1'b0) begin n_fail++; $display("FAIL en_niowmbr: got %b expected 0", niowmbr); end
    nw = 1'b1; #1;
    n_chk++; if (niowmbr !== 1'b1) begin n_fail++; $display("FAIL en_niowmbr_rel: got %b expected 1", niowmbr); end
    n_chk++; if (nen !== 1'b0 || ndis !== 1'b1) begin n_fail++; $display("FAIL en_latched: got nen=%b ndis=%b expected 0/1", nen, ndis); end
    rd = 8'h3C; #1;
    n_chk++; if (aext !== 8'h3C) begin n_fail++; $display("FAIL en_aext: got %h expected 3c", aext); end
    ab = 8'h00; nsysdev = 1'b1;
  endtask

  task automatic test_decode_sweep();
    int bad;
    bad = 0;
    nw = 1'b1;
    for (int a = 0; a < 512; a++) begin
      ab = a[7:0]; nsysdev = a[8]; #1;
      if (niombr !== !win_sel(ab, nsysdev)) begin
        bad++;
        if (bad < 4) $display("FAIL sweep_niombr: ab=%h nsysdev=%b got %b expected %b", ab, nsysdev, niombr, !win_sel(ab, nsysdev));
      end
    end
    n_chk++; if (bad != 0) n_fail++;
    bad = 0;
    for (int r = 0; r < 64; r++) begin
      raddr = r[4:0]; t34 = r[5]; #1;
      if (nrmbp !== !rmbp_sel(raddr, t34)) begin
        bad++;
        if (bad < 4) $display("FAIL sweep_nrmbp: raddr=%b t34=%b got %b expected %b", raddr, t34, nrmbp, !rmbp_sel(raddr, t34));
      end
    end
    n_chk++; if (bad != 0) n_fail++;
    bad = 0;
    for (int w = 0; w < 32; w++) begin
      waddr = w[4:0]; #1;
      if (nwmbp !== !wmbp_sel(waddr) || nwar !== !war_sel(waddr)) begin
        bad++;
        if (bad < 4) $display("FAIL sweep_waddr: waddr=%b got nwmbp=%b nwar=%b expected %b %b", waddr, nwmbp, nwar, !wmbp_sel(waddr), !war_sel(waddr));
      end
    end
    n_chk++; if (bad != 0) n_fail++;
    ab = 8'h00; nsysdev = 1'b1; raddr = 5'd0; t34 = 1'b1; waddr = 5'd0; #1;
  endtask

  task automatic test_bus_out();
    // MBU enabled by test_enable, rd=3C so aext is non-zero
    n_chk++; if (ibus !== 8'hzz && ibus !== 8'h00) begin n_fail++; $display("FAIL bus_ibus_idle: got %h expected released", ibus); end
    raddr = 5'b01101; t34 = 1'b0; #1;
    n_chk++; if (ibus !== 8'h3C) begin n_fail++; $display("FAIL bus_ibus: got %h expected 3c", ibus); end
    t34 = 1'b1; #1;
    n_chk++; if (ibus !== 8'hzz && ibus !== 8'h00) begin n_fail++; $display("FAIL bus_ibus_t34: got %h expected released", ibus); end
    ab = 8'h09; nsysdev = 1'b0; nr = 1'b0; #1;
    n_chk++; if (db !== 16'h543C) begin n_fail++; $display("FAIL bus_db: got %h expected 543c", db); end
    nr = 1'b1; #1;
    n_chk++; if (db !== 16'hzzzz && db !== 16'h0000) begin n_fail++; $display("FAIL bus_db_rel: got %h expected released", db); end
    raddr = 5'd0; ab = 8'h00; nsysdev = 1'b1;
  endtask

  task automatic test_index();
    @(negedge clk) nir_idx = 1'b0; #1;
    n_chk++; if (nir_idxreg !== 1'b0) begin n_fail++; $display("FAIL idx_set: got %b expected 0", nir_idxreg); end
    @(posedge clk) #1;
    n_chk++; if (nir_idxreg !== 1'b0) begin n_fail++; $display("FAIL idx_hold_while_low: got %b expected 0", nir_idxreg); end
    @(negedge clk) nir_idx = 1'b1; #1;
    n_chk++; if (nir_idxreg !== 1'b0) begin n_fail++; $display("FAIL idx_before_edge: got %b expected 0", nir_idxreg); end
    @(posedge clk) #1;
    n_chk++; if (nir_idxreg !== 1'b1) begin n_fail++; $display("FAIL idx_clear_edge: got %b expected 1", nir_idxreg); end
    @(negedge clk) nir_idx = 1'b0; #1 nreset = 1'b0; #1;
    n_chk++; if (nir_idxreg !== 1'b1) begin n_fail++; $display("FAIL idx_reset_prio: got %b expected 1", nir_idxreg); end
    n_chk++; if (nen !== 1'b1) begin n_fail++; $display("FAIL idx_reset_nen: got %b expected 1", nen); end
    nir_idx = 1'b1; #1 nreset = 1'b1; #1;
  endtask

  task automatic test_random();
    logic [7:0] exp_aext;
    en_m = 1'b0; idx_m = 1'b0;
    if (nen === 1'b0) en_m = 1'b1;
    if (nir_idxreg === 1'b0) idx_m = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      raddr = 5'($urandom); waddr = 5'($urandom); t34 = 1'($urandom);
      ab = ($urandom_range(0, 1) != 0) ? (8'h08 | 8'($urandom_range(0, 7))) : 8'($urandom);
      nsysdev = ($urandom_range(0, 3) == 0);
      nr = ($urandom_range(0, 2) != 0);
      nw = ($urandom_range(0, 5) != 0);
      rd = 8'($urandom); nfpram_rom = 1'($urandom);
      nir_idx = ($urandom_range(0, 3) != 0);
      nreset = ($urandom_range(0, 24) != 0);
      if (!nreset) nir_idx = 1'b1;
      #1;
      if (!nreset) begin
        en_m = 1'b0; idx_m = 1'b0;
      end else begin
        if (win_sel(ab, nsysdev) && !nw) en_m = 1'b1;
        if (!nir_idx) idx_m = 1'b1;
      end
      exp_aext = aext_m();
      n_chk++; if (niombr !== !win_sel(ab, nsysdev)) begin n_fail++; $display("FAIL rnd_niombr[%0d]: got %b expected %b", i, niombr, !win_sel(ab, nsysdev)); end
      n_chk++; if (nrmbp !== !rmbp_sel(raddr, t34) || nwmbp !== !wmbp_sel(waddr) || nwar !== !war_sel(waddr))
        begin n_fail++; $display("FAIL rnd_cu_decode[%0d]: got %b%b%b expected %b%b%b", i, nrmbp, nwmbp, nwar, !rmbp_sel(raddr, t34), !wmbp_sel(waddr), !war_sel(waddr)); end
      n_chk++; if (niowmbr !== !(win_sel(ab, nsysdev) && !nw)) begin n_fail++; $display("FAIL rnd_niowmbr[%0d]: got %b expected %b", i, niowmbr, !(win_sel(ab, nsysdev) && !nw)); end
      n_chk++; if (nen !== !en_m || ndis !== en_m) begin n_fail++; $display("FAIL rnd_nen[%0d]: got nen=%b ndis=%b expected %b %b", i, nen, ndis, !en_m, en_m); end
      n_chk++; if (nir_idxreg !== !idx_m) begin n_fail++; $display("FAIL rnd_idx[%0d]: got %b expected %b", i, nir_idxreg, !idx_m); end
      n_chk++; if (aext !== exp_aext) begin n_fail++; $display("FAIL rnd_aext[%0d]: got %h expected %h", i, aext, exp_aext); end
      if (rmbp_sel(raddr, t34)) begin
        n_chk++; if (ibus !== exp_aext) begin n_fail++; $display("FAIL rnd_ibus[%0d]: got %h expected %h", i, ibus, exp_aext); end
      end
      if (win_sel(ab, nsysdev) && !nr) begin
        n_chk++; if (db !== {8'h54, exp_aext}) begin n_fail++; $display("FAIL rnd_db[%0d]: got %h expected %h", i, db, {8'h54, exp_aext}); end
      end
      @(posedge clk); #1;
      if (nreset && nir_idx) idx_m = 1'b0;
      n_chk++; if (nir_idxreg !== !idx_m) begin n_fail++; $display("FAIL rnd_idx_edge[%0d]: got %b expected %b", i, nir_idxreg, !idx_m); end
    end
  endtask

  initial begin
    test_reset();
    test_outside_window();
    test_decode_sweep();
    test_enable();
    test_bus_out();
    test_index();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
